tri_solve_sched: RTL and testbench

//  Job scheduler and matrix store for the back-substitution solver. Owns A/Y/X storage and

---
 rtl/tri_solve_sched.sv | 276 +++++++++++++++++++++++++++
 tb/tb_tri_solve_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_solve_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tri_solve_sched
//  Purpose  : Job scheduler and matrix store for the back-substitution solver.
//             Holds A (MAX_N x MAX_N), Y and X (MAX_N each). While RUN, the
//             solver gets zero-latency reads by opcode/i/j and writes X. Outside
//             RUN, a host port loads and reads back the same storage.
//             Sequences IDLE -> LOAD -> RUN -> DONE. Keeps the solver in reset
//             outside RUN.
//  Ports    : clk/rst_n        clock, async active-low reset
//             start/load_en/abort/n_cfg        job control
//             host_*           host storage port (granted outside RUN only)
//             slv_*            solver request/response and solver reset
//             busy/done/err/run_cycles         status
//  Revision : 1.0  initial release
// ============================================================================
module tri_solve_sched #(
    parameter int MAX_N   = 8,
    parameter int DW      = 20,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          load_en,
    input  logic          abort,
    input  logic [DW-1:0] n_cfg,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [1:0]    host_sel,
    input  logic [DW-1:0] host_row,
    input  logic [DW-1:0] host_col,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          slv_rst_n,
    input  logic [2:0]    slv_opcode,
    input  logic [DW-1:0] slv_i,
    input  logic [DW-1:0] slv_j,
    input  logic [DW-1:0] slv_out,
    input  logic          slv_fin,
    output logic [DW-1:0] slv_in,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] run_cycles
);

    localparam int AW  = $clog2(MAX_N);
    localparam int AAW = $clog2(MAX_N * MAX_N);

    localparam logic [2:0] c_OP_GET_N   = 3'b000;
    localparam logic [2:0] c_OP_READ_Y  = 3'b001;
    localparam logic [2:0] c_OP_READ_A  = 3'b010;
    localparam logic [2:0] c_OP_READ_X  = 3'b011;
    localparam logic [2:0] c_OP_WRITE_X = 3'b100;

    localparam logic [1:0] c_SEL_A = 2'b00;
    localparam logic [1:0] c_SEL_Y = 2'b01;
    localparam logic [1:0] c_SEL_X = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_n;
    logic [DW-1:0] r_host_rdata;
    logic          r_host_rvalid;
    logic          r_err;
    logic [DW-1:0] r_run_cycles;
    logic          r_slv_rst_n;

    // Storage is deliberately not reset: it is always reloaded by the host.
    logic [DW-1:0] r_mem_a [MAX_N*MAX_N];
    logic [DW-1:0] r_mem_y [MAX_N];
    logic [DW-1:0] r_mem_x [MAX_N];

    logic           w_in_run;
    logic           w_slv_i_ok;
    logic           w_slv_j_ok;
    logic [AW-1:0]  w_slv_i_idx;
    logic [AW-1:0]  w_slv_j_idx;
    logic [AAW-1:0] w_slv_a_addr;
    logic [DW-1:0]  w_slv_rdata;
    logic           w_slv_we;
    logic           w_slv_err;

    logic           w_host_gnt;
    logic           w_host_row_ok;
    logic           w_host_col_ok;
    logic           w_host_ok;
    logic [AW-1:0]  w_host_row_idx;
    logic [AAW-1:0] w_host_a_addr;
    logic [DW-1:0]  w_host_rd;
    logic           w_host_err;

    logic           w_n_ok;
    logic           w_timeout;
    logic           w_start_err;
    logic           w_timeout_err;
    logic           w_err_set;

    assign w_in_run = (r_state == ST_RUN);

    // ------------------------------------------------------------------
    // Solver side: indices are range-checked first, then truncated to
    // the address width so out-of-range values never alias a real entry.
    // ------------------------------------------------------------------
    assign w_slv_i_ok   = (slv_i < DW'(MAX_N));
    assign w_slv_j_ok   = (slv_j < DW'(MAX_N));
    assign w_slv_i_idx  = slv_i[AW-1:0];
    assign w_slv_j_idx  = slv_j[AW-1:0];
    assign w_slv_a_addr = AAW'(w_slv_i_idx) * AAW'(MAX_N) + AAW'(w_slv_j_idx);

    always_comb begin
        w_slv_rdata = '0;
        w_slv_we    = 1'b0;
        w_slv_err   = 1'b0;
        if (w_in_run) begin
            case (slv_opcode)
                c_OP_GET_N: w_slv_rdata = r_n;
                c_OP_READ_Y: begin
                    if (w_slv_i_ok) w_slv_rdata = r_mem_y[w_slv_i_idx];
                    else            w_slv_err   = 1'b1;
                end
                c_OP_READ_A: begin
                    if (w_slv_i_ok && w_slv_j_ok) w_slv_rdata = r_mem_a[w_slv_a_addr];
                    else                          w_slv_err   = 1'b1;
                end
                c_OP_READ_X: begin
                    if (w_slv_j_ok) w_slv_rdata = r_mem_x[w_slv_j_idx];
                    else            w_slv_err   = 1'b1;
                end
                c_OP_WRITE_X: begin
                    if (w_slv_i_ok) w_slv_we  = 1'b1;
                    else            w_slv_err = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Host side: locked out for the whole of RUN so the solver never stalls.
    // ------------------------------------------------------------------
    assign w_host_gnt     = host_req && !w_in_run;
    assign w_host_row_ok  = (host_row < DW'(MAX_N));
    assign w_host_col_ok  = (host_col < DW'(MAX_N));
    assign w_host_row_idx = host_row[AW-1:0];
    assign w_host_a_addr  = AAW'(w_host_row_idx) * AAW'(MAX_N) + AAW'(host_col[AW-1:0]);

    always_comb begin
        w_host_ok = 1'b0;
        w_host_rd = '0;
        case (host_sel)
            c_SEL_A: begin
                w_host_ok = w_host_row_ok && w_host_col_ok;
                if (w_host_ok) w_host_rd = r_mem_a[w_host_a_addr];
            end
            c_SEL_Y: begin
                w_host_ok = w_host_row_ok;
                if (w_host_ok) w_host_rd = r_mem_y[w_host_row_idx];
            end
            c_SEL_X: begin
                w_host_ok = w_host_row_ok;
                if (w_host_ok) w_host_rd = r_mem_x[w_host_row_idx];
            end
            default: ;
        endcase
    end

    assign w_host_err = w_host_gnt && !w_host_ok;

    // Solver and host writes are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (w_slv_we) begin
            r_mem_x[w_slv_i_idx] <= slv_out;
        end else if (w_host_gnt && host_we && w_host_ok) begin
            case (host_sel)
                c_SEL_A: r_mem_a[w_host_a_addr]  <= host_wdata;
                c_SEL_Y: r_mem_y[w_host_row_idx] <= host_wdata;
                c_SEL_X: r_mem_x[w_host_row_idx] <= host_wdata;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control and error sources. A timeout coinciding with fin is a
    // normal completion; abort suppresses the start/timeout errors.
    // ------------------------------------------------------------------
    assign w_n_ok        = (n_cfg != '0) && (n_cfg <= DW'(MAX_N));
    assign w_timeout     = (r_run_cycles == DW'(TIMEOUT - 1));
    assign w_start_err   = (r_state == ST_LOAD) && start && !abort && !w_n_ok;
    assign w_timeout_err = w_in_run && !abort && !slv_fin && w_timeout;
    assign w_err_set     = w_slv_err || w_host_err || w_start_err || w_timeout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_n           <= '0;
            r_host_rdata  <= '0;
            r_host_rvalid <= 1'b0;
            r_err         <= 1'b0;
            r_run_cycles  <= '0;
            r_slv_rst_n   <= 1'b0;
        end else begin
            r_host_rvalid <= w_host_gnt && !host_we;
            if (w_host_gnt && !host_we) begin
                r_host_rdata <= w_host_rd;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (load_en) begin
                r_err <= 1'b0;
            end

            if (w_in_run && (r_run_cycles != '1)) begin
                r_run_cycles <= r_run_cycles + 1'b1;
            end

            if (abort) begin
                r_state     <= ST_IDLE;
                r_slv_rst_n <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (load_en) r_state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (start && w_n_ok) begin
                            r_state      <= ST_RUN;
                            r_n          <= n_cfg;
                            r_run_cycles <= '0;
                            r_slv_rst_n  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (slv_fin) begin
                            r_state     <= ST_DONE;
                            r_slv_rst_n <= 1'b0;
                        end else if (w_timeout) begin
                            r_state     <= ST_IDLE;
                            r_slv_rst_n <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        if (load_en) r_state <= ST_LOAD;
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_slv_rst_n <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign host_gnt    = w_host_gnt;
    assign host_rdata  = r_host_rdata;
    assign host_rvalid = r_host_rvalid;
    assign slv_rst_n   = r_slv_rst_n;
    assign slv_in      = w_slv_rdata;
    assign busy        = w_in_run;
    assign done        = (r_state == ST_DONE);
    assign err         = r_err;
    assign run_cycles  = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_tri_solve_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tri_solve_sched
//  Purpose  : Self-checking bench for tri_solve_sched. A stub solver drives
//             opcode sequences for back-substitution; results are compared to
//             an arithmetic reference kept in plain arrays.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tri_solve_sched;

    localparam int MAX_N   = 8;
    localparam int DW      = 20;
    localparam int TIMEOUT = 16;

    localparam logic [2:0] OP_GET_N   = 3'b000;
    localparam logic [2:0] OP_READ_Y  = 3'b001;
    localparam logic [2:0] OP_READ_A  = 3'b010;
    localparam logic [2:0] OP_READ_X  = 3'b011;
    localparam logic [2:0] OP_WRITE_X = 3'b100;
    localparam logic [2:0] OP_INIT    = 3'b101;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, load_en = 1'b0, abort = 1'b0;
    logic [DW-1:0] n_cfg = '0;
    logic          host_req = 1'b0, host_we = 1'b0;
    logic [1:0]    host_sel = 2'b00;
    logic [DW-1:0] host_row = '0, host_col = '0, host_wdata = '0;
    logic          host_gnt, host_rvalid, slv_rst_n, busy, done, err;
    logic [DW-1:0] host_rdata, slv_in, run_cycles;
    logic [2:0]    slv_opcode = OP_INIT;
    logic [DW-1:0] slv_i = '0, slv_j = '0, slv_out = '0;
    logic          slv_fin = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference storage model
    logic [DW-1:0] mA [MAX_N][MAX_N];
    logic [DW-1:0] mY [MAX_N];
    logic [DW-1:0] mX [MAX_N];
    bit            wA [MAX_N][MAX_N];
    bit            wY [MAX_N];
    bit            wX [MAX_N];

    tri_solve_sched #(.MAX_N(MAX_N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_en(load_en), .abort(abort),
        .n_cfg(n_cfg), .host_req(host_req), .host_we(host_we), .host_sel(host_sel),
        .host_row(host_row), .host_col(host_col), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .slv_rst_n(slv_rst_n), .slv_opcode(slv_opcode), .slv_i(slv_i), .slv_j(slv_j),
        .slv_out(slv_out), .slv_fin(slv_fin), .slv_in(slv_in), .busy(busy),
        .done(done), .err(err), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checks inside) ----------------
    task automatic pulse_load();
        @(negedge clk); load_en = 1'b1;
        @(posedge clk); #1 load_en = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
    endtask

    task automatic do_start(input int n);
        @(negedge clk); start = 1'b1; n_cfg = DW'(n);
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic host_wr(input logic [1:0] sel, input int row, input int col,
                           input logic [DW-1:0] d);
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_sel = sel;
        host_row = DW'(row); host_col = DW'(col); host_wdata = d;
        @(posedge clk); #1 host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_rd(input logic [1:0] sel, input int row, input int col,
                           output logic [DW-1:0] d, output logic v, output logic g);
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_sel = sel;
        host_row = DW'(row); host_col = DW'(col);
        #1 g = host_gnt;
        @(posedge clk); #1 host_req = 1'b0;
        d = host_rdata; v = host_rvalid;
    endtask

    task automatic slv_step(input logic [2:0] op, input int i, input int j,
                            input logic [DW-1:0] o, input logic f,
                            output logic [DW-1:0] rd);
        @(negedge clk);
        slv_opcode = op; slv_i = DW'(i); slv_j = DW'(j); slv_out = o; slv_fin = f;
        #1 rd = slv_in;
    endtask

    task automatic slv_release();
        @(posedge clk); #1
        slv_opcode = OP_INIT; slv_fin = 1'b0; slv_i = '0; slv_j = '0;
    endtask

    // Back-substitution on a unit upper-triangular system, modulo 2^DW.
    function automatic void ref_solve(input int n);
        logic [DW-1:0] s;
        for (int i = n - 1; i >= 0; i--) begin
            s = mY[i];
            for (int j = i + 1; j < n; j++) s = s - mA[i][j] * mX[j];
            mX[i] = s;
            wX[i] = 1'b1;
        end
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_state busy=%b done=%b exp 0/0", busy, done); end
        n_checks++; if (slv_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_slv_rst_n got %b exp 0", slv_rst_n); end
        n_checks++; if (err !== 1'b0 || host_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_flags err=%b rvalid=%b exp 0/0", err, host_rvalid); end
        n_checks++; if (run_cycles !== '0 || host_rdata !== '0 || slv_in !== '0) begin n_fail++; $display("FAIL reset_values run=%0d rdata=%h slv_in=%h exp 0", run_cycles, host_rdata, slv_in); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    // Loads model A/Y for order n into the DUT, runs the stub solver, checks
    // every served read and the final X readback.
    task automatic run_solve(input int n);
        logic [DW-1:0] rd, acc, a, x, xe [MAX_N];
        logic v, g;
        int cyc;
        pulse_load();
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) host_wr(2'b00, r, c, mA[r][c]);
            host_wr(2'b01, r, 0, mY[r]);
        end
        ref_solve(n);
        for (int k = 0; k < n; k++) xe[k] = mX[k];
        do_start(n);
        cyc = 0;
        slv_step(OP_GET_N, 0, 0, '0, 1'b0, rd); cyc++;
        n_checks++; if (rd !== DW'(n) || busy !== 1'b1 || slv_rst_n !== 1'b1) begin n_fail++; $display("FAIL get_n got %0d busy=%b srst=%b exp %0d/1/1", rd, busy, slv_rst_n, n); end
        for (int i = n - 1; i >= 0; i--) begin
            slv_step(OP_READ_Y, i, 0, '0, 1'b0, rd); cyc++;
            n_checks++; if (rd !== mY[i]) begin n_fail++; $display("FAIL read_y[%0d] got %h exp %h", i, rd, mY[i]); end
            acc = rd;
            for (int j = i + 1; j < n; j++) begin
                slv_step(OP_READ_A, i, j, '0, 1'b0, a); cyc++;
                n_checks++; if (a !== mA[i][j]) begin n_fail++; $display("FAIL read_a[%0d][%0d] got %h exp %h", i, j, a, mA[i][j]); end
                slv_step(OP_READ_X, 0, j, '0, 1'b0, x); cyc++;
                n_checks++; if (x !== xe[j]) begin n_fail++; $display("FAIL read_x[%0d] got %h exp %h", j, x, xe[j]); end
                acc = acc - a * x;
            end
            slv_step(OP_WRITE_X, i, 0, acc, 1'b0, rd); cyc++;
        end
        slv_step(OP_INIT, 0, 0, '0, 1'b1, rd); cyc++;
        slv_release();
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || slv_rst_n !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL solve_done done=%b busy=%b srst=%b err=%b exp 1/0/0/0", done, busy, slv_rst_n, err); end
        n_checks++; if (run_cycles !== DW'(cyc)) begin n_fail++; $display("FAIL solve_run_cycles got %0d exp %0d", run_cycles, cyc); end
        for (int k = 0; k < n; k++) begin
            host_rd(2'b10, k, 0, rd, v, g);
            n_checks++; if (rd !== xe[k] || v !== 1'b1 || g !== 1'b1) begin n_fail++; $display("FAIL x_readback[%0d] got %h v=%b g=%b exp %h 1 1", k, rd, v, g, xe[k]); end
        end
    endtask

    task automatic test_directed_solve();
        logic [DW-1:0] rd; logic v, g;
        mA[0][0] = 1; mA[0][1] = 2; mA[1][0] = 0; mA[1][1] = 1;
        mY[0] = 5; mY[1] = 3;
        run_solve(2);
        host_rd(2'b10, 0, 0, rd, v, g);
        n_checks++; if (rd !== 20'hFFFFF) begin n_fail++; $display("FAIL directed_x0 got %h exp fffff", rd); end
        host_rd(2'b10, 1, 0, rd, v, g);
        n_checks++; if (rd !== 20'h00003) begin n_fail++; $display("FAIL directed_x1 got %h exp 00003", rd); end
    endtask

    task automatic test_random_solves();
        int n;
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(1, 3));
            for (int r = 0; r < n; r++) begin
                for (int c = 0; c < n; c++) mA[r][c] = (r == c) ? DW'(1) : DW'($urandom);
                mY[r] = DW'($urandom);
            end
            run_solve(n);
        end
    endtask

    task automatic test_bad_n();
        pulse_load();
        do_start(0);
        n_checks++; if (err !== 1'b1 || busy !== 1'b0 || slv_rst_n !== 1'b0) begin n_fail++; $display("FAIL bad_n0 err=%b busy=%b srst=%b exp 1/0/0", err, busy, slv_rst_n); end
        pulse_load();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err); end
        do_start(MAX_N + 1);
        n_checks++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bad_n9 err=%b busy=%b exp 1/0", err, busy); end
        pulse_load();
        do_start(MAX_N);
        n_checks++; if (busy !== 1'b1 || err !== 1'b0 || run_cycles !== '0) begin n_fail++; $display("FAIL n_max_start busy=%b err=%b run=%0d exp 1/0/0", busy, err, run_cycles); end
        pulse_abort();
        n_checks++; if (busy !== 1'b0 || slv_rst_n !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL abort_run busy=%b srst=%b err=%b exp 0/0/0", busy, slv_rst_n, err); end
    endtask

    task automatic test_host_in_run();
        logic [DW-1:0] d, vy; logic v, g;
        vy = DW'($urandom);
        pulse_load();
        host_wr(2'b01, 1, 0, vy); mY[1] = vy; wY[1] = 1'b1;
        do_start(2);
        host_rd(2'b01, 1, 0, d, v, g);
        n_checks++; if (g !== 1'b0 || v !== 1'b0) begin n_fail++; $display("FAIL run_host_read gnt=%b rvalid=%b exp 0/0", g, v); end
        host_wr(2'b01, 1, 0, ~vy);
        pulse_abort();
        host_rd(2'b01, 1, 0, d, v, g);
        n_checks++; if (d !== mY[1] || v !== 1'b1) begin n_fail++; $display("FAIL y_unchanged got %h v=%b exp %h 1", d, v, mY[1]); end
    endtask

    task automatic test_reset_mid_run();
        logic [DW-1:0] d, rd; logic v, g;
        pulse_load();
        host_wr(2'b01, 0, 0, 20'h1A2B3); mY[0] = 20'h1A2B3; wY[0] = 1'b1;
        do_start(3);
        for (int k = 0; k < 3; k++) slv_step(OP_INIT, 0, 0, '0, 1'b0, rd);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || slv_rst_n !== 1'b0 || run_cycles !== '0 || err !== 1'b0) begin n_fail++; $display("FAIL async_reset busy=%b srst=%b run=%0d err=%b exp 0/0/0/0", busy, slv_rst_n, run_cycles, err); end
        @(negedge clk); rst_n = 1'b1;
        host_rd(2'b01, 0, 0, d, v, g);
        n_checks++; if (d !== mY[0]) begin n_fail++; $display("FAIL storage_kept got %h exp %h", d, mY[0]); end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] rd;
        int cnt;
        pulse_load();
        do_start(2);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(posedge clk); #1;
        end
        n_checks++; if (cnt != TIMEOUT) begin n_fail++; $display("FAIL timeout_cycles got %0d exp %0d", cnt, TIMEOUT); end
        n_checks++; if (err !== 1'b1 || done !== 1'b0 || slv_rst_n !== 1'b0 || run_cycles !== DW'(TIMEOUT)) begin n_fail++; $display("FAIL timeout_state err=%b done=%b srst=%b run=%0d exp 1/0/0/%0d", err, done, slv_rst_n, run_cycles, TIMEOUT); end
        // fin on the very last allowed cycle wins over timeout
        pulse_load();
        do_start(1);
        for (int k = 0; k < TIMEOUT - 1; k++) slv_step(OP_INIT, 0, 0, '0, 1'b0, rd);
        slv_step(OP_INIT, 0, 0, '0, 1'b1, rd);
        slv_release();
        n_checks++; if (done !== 1'b1 || err !== 1'b0 || run_cycles !== DW'(TIMEOUT)) begin n_fail++; $display("FAIL fin_at_timeout done=%b err=%b run=%0d exp 1/0/%0d", done, err, run_cycles, TIMEOUT); end
    endtask

    task automatic test_bad_index();
        logic [DW-1:0] rd, d; logic v, g;
        pulse_load();
        host_wr(2'b00, 0, 0, 20'h00077); mA[0][0] = 20'h00077; wA[0][0] = 1'b1;
        host_wr(2'b10, 0, 0, 20'h00055); mX[0] = 20'h00055; wX[0] = 1'b1;
        do_start(2);
        slv_step(OP_READ_A, MAX_N, 0, '0, 1'b0, rd);
        n_checks++; if (rd !== '0) begin n_fail++; $display("FAIL bad_read_a got %h exp 0", rd); end
        slv_step(OP_WRITE_X, MAX_N, 0, 20'h12345, 1'b0, rd);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_idx_err got %b exp 1", err); end
        slv_step(OP_INIT, 0, 0, '0, 1'b1, rd);
        slv_release();
        host_rd(2'b10, 0, 0, d, v, g);
        n_checks++; if (d !== mX[0]) begin n_fail++; $display("FAIL bad_write_dropped got %h exp %h", d, mX[0]); end
        host_rd(2'b11, 0, 0, d, v, g);
        n_checks++; if (d !== '0 || v !== 1'b1) begin n_fail++; $display("FAIL sel11_read got %h v=%b exp 0 1", d, v); end
        pulse_load();
        host_rd(2'b01, MAX_N, 0, d, v, g);
        n_checks++; if (d !== '0 || v !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL host_oob got %h v=%b err=%b exp 0 1 1", d, v, err); end
        pulse_load();
        @(negedge clk); start = 1'b1; abort = 1'b1; n_cfg = DW'(2);
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort busy=%b exp 0", busy); end
        do_start(2);
        n_checks++; if (busy !== 1'b0 || slv_rst_n !== 1'b0) begin n_fail++; $display("FAIL idle_ignores_start busy=%b srst=%b exp 0/0", busy, slv_rst_n); end
    endtask

    task automatic test_host_random();
        logic [DW-1:0] d, dv; logic v, g;
        int r, c, s;
        pulse_load();
        for (int k = 0; k < 24; k++) begin
            s = int'($urandom_range(0, 2)); r = int'($urandom_range(0, MAX_N - 1));
            c = int'($urandom_range(0, MAX_N - 1)); dv = DW'($urandom);
            host_wr(2'(s), r, c, dv);
            if (s == 0) begin mA[r][c] = dv; wA[r][c] = 1'b1; end
            else if (s == 1) begin mY[r] = dv; wY[r] = 1'b1; end
            else begin mX[r] = dv; wX[r] = 1'b1; end
        end
        for (int k = 0; k < 24; k++) begin
            s = int'($urandom_range(0, 2)); r = int'($urandom_range(0, MAX_N - 1));
            c = int'($urandom_range(0, MAX_N - 1));
            if ((s == 0 && wA[r][c]) || (s == 1 && wY[r]) || (s == 2 && wX[r])) begin
                dv = (s == 0) ? mA[r][c] : (s == 1) ? mY[r] : mX[r];
                host_rd(2'(s), r, c, d, v, g);
                n_checks++; if (d !== dv || v !== 1'b1) begin n_fail++; $display("FAIL host_rand sel=%0d r=%0d c=%0d got %h v=%b exp %h 1", s, r, c, d, v, dv); end
            end
        end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL host_rand_err got %b exp 0", err); end
    endtask

    initial begin
        for (int r = 0; r < MAX_N; r++) begin
            wY[r] = 1'b0; wX[r] = 1'b0; mY[r] = '0; mX[r] = '0;
            for (int c = 0; c < MAX_N; c++) begin wA[r][c] = 1'b0; mA[r][c] = '0; end
        end
        test_reset();
        test_directed_solve();
        test_random_solves();
        test_bad_n();
        test_host_in_run();
        test_reset_mid_run();
        test_timeout();
        test_bad_index();
        test_host_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
